// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-side signals of the data-memory arbiter.
// The arbiter sits on the slave side; requesters and memory on the master.
interface dmem_arbiter_if;
   logic        req0_valid, req0_ready, req0_we, req0_lock;
   logic [31:0] req0_addr, req0_wdata;
   logic [1:0]  req0_size;
   logic        req1_valid, req1_ready, req1_we, req1_lock;
   logic [31:0] req1_addr, req1_wdata;
   logic [1:0]  req1_size;

   logic        resp0_valid, resp0_err;
   logic [31:0] resp0_rdata;
   logic        resp1_valid, resp1_err;
   logic [31:0] resp1_rdata;

   logic        mem_read_en, mem_write_en;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic [1:0]  mem_store_size;

   modport slave (
      input  req0_valid, req0_we, req0_lock, req0_addr, req0_size, req0_wdata,
      input  req1_valid, req1_we, req1_lock, req1_addr, req1_size, req1_wdata,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_err, resp0_rdata,
      output resp1_valid, resp1_err, resp1_rdata,
      output mem_read_en, mem_write_en, mem_addr, mem_store_size,
      output mem_write_data,
      input  mem_read_data
   );

   modport master (
      output req0_valid, req0_we, req0_lock, req0_addr, req0_size, req0_wdata,
      output req1_valid, req1_we, req1_lock, req1_addr, req1_size, req1_wdata,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_err, resp0_rdata,
      input  resp1_valid, resp1_err, resp1_rdata,
      input  mem_read_en, mem_write_en, mem_addr, mem_store_size,
      input  mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded bus lock between the LSU (port 0)
// and the debug/DMA port (port 1) in front of the data memory.
module dmem_arbiter #(
   parameter int unsigned MEM_SIZE = 512,
   parameter int unsigned LOCK_MAX = 8
) (
   input logic           clk,
   input logic           reset_n,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_P0,
      OWN_P1
   } own_e;

   localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

   own_e        own_q, own_d, gnt_own;
   logic [7:0]  cnt_q, cnt_d;
   logic        rr_q, rr_d;
   logic        rsp_vld_q, rsp_port_q, rsp_err_q, rsp_we_q;

   logic [1:0]  vld;
   logic        own_held, own_id, own_vld;
   logic        gnt_any, gnt_id;
   logic        g_we, g_lk, g_err, g_ok;
   logic [31:0] g_addr, g_wdata;
   logic [1:0]  g_size;
   logic [2:0]  g_bytes;
   logic [32:0] g_end;
   logic        r0_vld, r1_vld, rsp_load;

   assign vld      = {bus.req1_valid, bus.req0_valid};
   assign own_held = (own_q != OWN_NONE);
   assign own_id   = (own_q == OWN_P1);
   assign own_vld  = own_held && vld[own_id];

   // An idle lock owner leaves at most the other port valid,
   // so that case falls through to the single-request branch.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = 1'b0;
      if (!reset_n) begin
         gnt_any = 1'b0;
      end else if (own_vld) begin
         gnt_any = 1'b1;
         gnt_id  = own_id;
      end else if (&vld) begin
         gnt_any = 1'b1;
         gnt_id  = rr_q;
      end else if (|vld) begin
         gnt_any = 1'b1;
         gnt_id  = vld[1];
      end
   end

   assign gnt_own = gnt_id ? OWN_P1 : OWN_P0;
   assign g_we    = gnt_id ? bus.req1_we    : bus.req0_we;
   assign g_lk    = gnt_id ? bus.req1_lock  : bus.req0_lock;
   assign g_addr  = gnt_id ? bus.req1_addr  : bus.req0_addr;
   assign g_size  = gnt_id ? bus.req1_size  : bus.req0_size;
   assign g_wdata = gnt_id ? bus.req1_wdata : bus.req0_wdata;

   // End address in 33 bits so addresses near 0xFFFFFFFF cannot wrap.
   always_comb begin
      g_bytes = 3'd0;
      g_err   = 1'b0;
      unique case (g_size)
         2'b00: g_bytes = 3'd1;
         2'b01: begin
            g_bytes = 3'd2;
            g_err   = g_addr[0];
         end
         2'b10: begin
            g_bytes = 3'd4;
            g_err   = |g_addr[1:0];
         end
         default: g_err = 1'b1;
      endcase
      g_end = {1'b0, g_addr} + {30'd0, g_bytes};
      if (g_end > 33'(MEM_SIZE)) g_err = 1'b1;
   end

   assign g_ok = gnt_any && !g_err;

   assign bus.req0_ready     = gnt_any && !gnt_id;
   assign bus.req1_ready     = gnt_any && gnt_id;
   assign bus.mem_read_en    = g_ok && !g_we;
   assign bus.mem_write_en   = g_ok && g_we;
   assign bus.mem_addr       = g_ok ? g_addr  : 32'd0;
   assign bus.mem_store_size = g_ok ? g_size  : 2'd0;
   assign bus.mem_write_data = g_ok ? g_wdata : 32'd0;

   always_comb begin
      own_d = own_q;
      cnt_d = cnt_q;
      rr_d  = rr_q;
      if (own_held && !own_vld) begin
         own_d = OWN_NONE;
         cnt_d = 8'd0;
      end
      if (gnt_any) begin
         rr_d = !gnt_id;
         if (g_lk) begin
            cnt_d = (own_d == gnt_own) ? cnt_d + 8'd1 : 8'd1;
            own_d = gnt_own;
            if (cnt_d == LOCK_LIM) begin
               own_d = OWN_NONE;
               cnt_d = 8'd0;
            end
         end else if (own_d == gnt_own) begin
            own_d = OWN_NONE;
            cnt_d = 8'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         own_q      <= OWN_NONE;
         cnt_q      <= 8'd0;
         rr_q       <= 1'b0;
         rsp_vld_q  <= 1'b0;
         rsp_port_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         rsp_we_q   <= 1'b0;
      end else begin
         own_q      <= own_d;
         cnt_q      <= cnt_d;
         rr_q       <= rr_d;
         rsp_vld_q  <= gnt_any;
         rsp_port_q <= gnt_id;
         rsp_err_q  <= g_err;
         rsp_we_q   <= g_we;
      end
   end

   assign r0_vld   = rsp_vld_q && !rsp_port_q;
   assign r1_vld   = rsp_vld_q && rsp_port_q;
   assign rsp_load = !rsp_err_q && !rsp_we_q;

   assign bus.resp0_valid = r0_vld;
   assign bus.resp1_valid = r1_vld;
   assign bus.resp0_err   = r0_vld && rsp_err_q;
   assign bus.resp1_err   = r1_vld && rsp_err_q;
   assign bus.resp0_rdata = (r0_vld && rsp_load) ? bus.mem_read_data : 32'd0;
   assign bus.resp1_rdata = (r1_vld && rsp_load) ? bus.mem_read_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run
// against a rule-level arbitration and byte-array memory model.
module tb_dmem_arbiter;
   localparam int MSZ  = 512;
   localparam int LMAX = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   int   n_chk   = 0;
   int   n_err   = 0;

   always #5 clk = ~clk;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MEM_SIZE(MSZ), .LOCK_MAX(LMAX)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Synchronous single-port memory, little-endian bytes.
   logic [7:0] smem [MSZ] = '{default: 8'h00};
   always @(posedge clk) begin : mem_model
      int b;
      b = int'({bus.mem_addr[8:2], 2'b00});
      if (bus.mem_write_en)
         for (int k = 0; k < 4; k++)
            if (k < (1 << bus.mem_store_size))
               smem[int'(bus.mem_addr[8:0]) + k] <= bus.mem_write_data[8*k +: 8];
      if (bus.mem_read_en)
         bus.mem_read_data <= {smem[b+3], smem[b+2], smem[b+1], smem[b]};
   end

   logic [7:0]  ref_mem [MSZ] = '{default: 8'h00};
   logic        rq_v [2], rq_we [2], rq_lk [2];
   logic [31:0] rq_a [2], rq_wd [2];
   logic [1:0]  rq_sz [2];
   int          m_fav, m_own, m_cnt;

   logic        s_rdy0, s_rdy1, s_re, s_we;
   logic [31:0] s_addr, s_wd;
   logic [1:0]  s_sz;
   logic        s_rv0, s_rv1, s_er0, s_er1;
   logic [31:0] s_rd0, s_rd1;

   task automatic drive();
      bus.req0_valid = rq_v[0];  bus.req1_valid = rq_v[1];
      bus.req0_we    = rq_we[0]; bus.req1_we    = rq_we[1];
      bus.req0_lock  = rq_lk[0]; bus.req1_lock  = rq_lk[1];
      bus.req0_addr  = rq_a[0];  bus.req1_addr  = rq_a[1];
      bus.req0_size  = rq_sz[0]; bus.req1_size  = rq_sz[1];
      bus.req0_wdata = rq_wd[0]; bus.req1_wdata = rq_wd[1];
   endtask

   task automatic set_req(input int p, input logic v, input logic we,
                          input logic lk, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] wd);
      rq_v[p] = v; rq_we[p] = we; rq_lk[p] = lk;
      rq_a[p] = a; rq_sz[p] = sz; rq_wd[p] = wd;
      drive();
   endtask

   task automatic clear_reqs();
      for (int p = 0; p < 2; p++) set_req(p, 0, 0, 0, 32'd0, 2'd0, 32'd0);
   endtask

   // Called at a negedge; samples requests-side outputs before the edge
   // and responses just after it, then returns at the next negedge.
   task automatic step();
      #1;
      s_rdy0 = bus.req0_ready;  s_rdy1 = bus.req1_ready;
      s_re   = bus.mem_read_en; s_we   = bus.mem_write_en;
      s_addr = bus.mem_addr;    s_sz   = bus.mem_store_size;
      s_wd   = bus.mem_write_data;
      @(posedge clk);
      #1;
      s_rv0 = bus.resp0_valid; s_rv1 = bus.resp1_valid;
      s_er0 = bus.resp0_err;   s_er1 = bus.resp1_err;
      s_rd0 = bus.resp0_rdata; s_rd1 = bus.resp1_rdata;
      @(negedge clk);
   endtask

   task automatic do_reset();
      clear_reqs();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      m_fav = 0; m_own = -1; m_cnt = 0;
   endtask

   function automatic int m_pick(logic v0, logic v1);
      if (m_own == 0 && v0) return 0;
      if (m_own == 1 && v1) return 1;
      if (v0 && v1) return m_fav;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic m_update(input int g, input logic lk, input logic own_v);
      if (m_own >= 0 && !own_v) begin m_own = -1; m_cnt = 0; end
      if (g >= 0) begin
         m_fav = 1 - g;
         if (lk) begin
            if (m_own != g) begin m_own = g; m_cnt = 0; end
            m_cnt++;
            if (m_cnt == LMAX) begin m_own = -1; m_cnt = 0; end
         end else if (m_own == g) begin
            m_own = -1; m_cnt = 0;
         end
      end
   endtask

   function automatic logic exp_err(logic [31:0] a, logic [1:0] sz);
      longint n;
      if (sz == 2'd3) return 1'b1;
      n = longint'(1) << sz;
      if ((longint'(a) % n) != 0) return 1'b1;
      return (longint'(a) + n) > MSZ;
   endfunction

   task automatic test_reset();
      set_req(0, 1, 0, 0, 32'h10, 2'd2, 32'd0);
      set_req(1, 1, 0, 0, 32'h14, 2'd2, 32'd0);
      #1;
      n_chk++;
      if ({bus.req0_ready, bus.req1_ready, bus.mem_read_en, bus.mem_write_en} !== 4'b0) begin
         n_err++;
         $display("FAIL reset_out got=%b exp=0000", {bus.req0_ready,
                  bus.req1_ready, bus.mem_read_en, bus.mem_write_en});
      end
      @(posedge clk);
      #1;
      n_chk++;
      if ({bus.resp0_valid, bus.resp1_valid, bus.resp0_rdata, bus.resp1_rdata} !== 66'd0) begin
         n_err++;
         $display("FAIL reset_resp got=%b/%b exp=0/0", bus.resp0_valid, bus.resp1_valid);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_chk++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_tie got=%b exp=10", {bus.req0_ready, bus.req1_ready});
      end
      clear_reqs();
   endtask

   task automatic test_single_load();
      do_reset();
      set_req(0, 1, 1, 0, 32'h10, 2'd2, 32'hDEADBEEF);
      step();
      n_chk++;
      if ({s_rdy0, s_we, s_re, s_addr, s_sz, s_wd} !== {3'b110, 32'h10, 2'd2, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL store_drive got=%b %b %b %h %h exp=1 1 0 10 deadbeef",
                  s_rdy0, s_we, s_re, s_addr, s_wd);
      end
      n_chk++;
      if ({s_rv0, s_er0, s_rd0} !== {2'b10, 32'd0}) begin
         n_err++;
         $display("FAIL store_resp got=%b %b %h exp=1 0 0", s_rv0, s_er0, s_rd0);
      end
      set_req(0, 1, 0, 0, 32'h10, 2'd2, 32'd0);
      step();
      n_chk++;
      if ({s_re, s_rv0, s_er0, s_rv1, s_rd0} !== {4'b1100, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL load_resp got=re%b v%b e%b v1%b %h exp=re1 v1 e0 v10 deadbeef",
                  s_re, s_rv0, s_er0, s_rv1, s_rd0);
      end
      clear_reqs();
      step();
      n_chk++;
      if (s_rv0 !== 1'b0) begin
         n_err++;
         $display("FAIL load_pulse got=%b exp=0", s_rv0);
      end
   endtask

   task automatic test_contention();
      do_reset();
      set_req(0, 1, 0, 0, 32'h100, 2'd2, 32'd0);
      set_req(1, 1, 0, 0, 32'h104, 2'd2, 32'd0);
      for (int i = 0; i < 6; i++) begin
         logic [1:0] ex;
         ex = (i % 2 == 0) ? 2'b10 : 2'b01;
         step();
         n_chk++;
         if ({s_rdy0, s_rdy1, s_rv0, s_rv1} !== {ex, ex}) begin
            n_err++;
            $display("FAIL contention[%0d] got=%b exp=%b", i,
                     {s_rdy0, s_rdy1, s_rv0, s_rv1}, {ex, ex});
         end
      end
      clear_reqs();
   endtask

   task automatic test_lock_limit();
      int seq [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 0};
      do_reset();
      set_req(1, 1, 0, 1, 32'h108, 2'd2, 32'd0);
      step();
      n_chk++;
      if ({s_rdy0, s_rdy1} !== 2'b01) begin
         n_err++;
         $display("FAIL lock_first got=%b exp=01", {s_rdy0, s_rdy1});
      end
      set_req(0, 1, 0, 0, 32'h10C, 2'd2, 32'd0);
      for (int i = 0; i < 9; i++) begin
         logic [1:0] ex;
         ex = (seq[i] == 0) ? 2'b10 : 2'b01;
         step();
         n_chk++;
         if ({s_rdy0, s_rdy1, s_rv0, s_rv1} !== {ex, ex}) begin
            n_err++;
            $display("FAIL lock_seq[%0d] got=%b exp=%b", i,
                     {s_rdy0, s_rdy1, s_rv0, s_rv1}, {ex, ex});
         end
      end
      clear_reqs();
   endtask

   task automatic test_errors();
      logic [31:0] ea [9] = '{32'h3, 32'h1FC, 32'h200, 32'hFFFFFFFC, 32'h0,
                              32'h1FF, 32'h1FE, 32'h200, 32'h5};
      logic [1:0]  es [9] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1};
      logic        ee [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic        ew [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         logic [31:0] xa;
         xa = ee[i] ? 32'd0 : ea[i];
         set_req(0, 1, ew[i], 0, ea[i], es[i], 32'h12345678);
         step();
         n_chk++;
         if ({s_rv0, s_er0, s_re, s_we, s_addr} !== {1'b1, ee[i], !ee[i] && !ew[i],
                                                     !ee[i] && ew[i], xa}) begin
            n_err++;
            $display("FAIL err[%0d] got=v%b e%b re%b we%b a=%h exp=v1 e%b a=%h",
                     i, s_rv0, s_er0, s_re, s_we, s_addr, ee[i], xa);
         end
      end
      clear_reqs();
   endtask

   task automatic test_reset_midflight();
      do_reset();
      set_req(0, 1, 0, 0, 32'h10, 2'd2, 32'd0);
      #1;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      clear_reqs();
      #1;
      n_chk++;
      if ({bus.resp0_valid, bus.resp0_rdata} !== 33'd0) begin
         n_err++;
         $display("FAIL midrst_resp got=%b %h exp=0 0", bus.resp0_valid, bus.resp0_rdata);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      step();
      n_chk++;
      if ({s_rv0, s_rv1} !== 2'b00) begin
         n_err++;
         $display("FAIL midrst_after got=%b exp=00", {s_rv0, s_rv1});
      end
      set_req(0, 1, 0, 0, 32'h100, 2'd2, 32'd0);
      set_req(1, 1, 0, 0, 32'h104, 2'd2, 32'd0);
      #1;
      n_chk++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL midrst_tie got=%b exp=10", {bus.req0_ready, bus.req1_ready});
      end
      clear_reqs();
   endtask

   task automatic test_abandon();
      do_reset();
      set_req(0, 1, 0, 1, 32'h110, 2'd2, 32'd0);
      step();
      set_req(1, 1, 1, 0, 32'h114, 2'd2, 32'hCAFEF00D);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            set_req(1, 0, 1, 0, 32'h114, 2'd2, 32'hCAFEF00D);
            set_req(0, 1, 0, 0, 32'h110, 2'd2, 32'd0);
         end
         if (i == 3) clear_reqs();
         step();
         n_chk++;
         if ({s_rdy1, s_we, s_rv1} !== 3'b000 || s_rdy0 !== (i < 3)) begin
            n_err++;
            $display("FAIL abandon[%0d] got=r0%b r1%b we%b v1%b exp=r0%b r1 0 we0 v10",
                     i, s_rdy0, s_rdy1, s_we, s_rv1, i < 3);
         end
      end
      n_chk++;
      if ({smem[32'h117], smem[32'h116], smem[32'h115], smem[32'h114]} !== 32'd0) begin
         n_err++;
         $display("FAIL abandon_mem got=%h exp=0",
                  {smem[32'h117], smem[32'h116], smem[32'h115], smem[32'h114]});
      end
   endtask

   task automatic gen_req(input int p);
      int r;
      logic [31:0] a;
      logic [1:0] sz;
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 2));
      a  = 32'h100 + 32'($urandom_range(0, 255));
      if (r < 7) a = a & ~((32'd1 << sz) - 32'd1);
      else if (r == 8) a = 32'h1F8 + 32'($urandom_range(0, 15));
      else if (r == 9) begin
         sz = 2'($urandom_range(2, 3));
         a  = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      end
      rq_v[p]  = ($urandom_range(0, 3) != 0);
      rq_we[p] = 1'($urandom_range(0, 1));
      rq_lk[p] = ($urandom_range(0, 2) == 0);
      rq_a[p]  = a;
      rq_sz[p] = sz;
      rq_wd[p] = $urandom;
   endtask

   task automatic test_random();
      int g, b;
      logic e, own_v;
      logic [67:0] ex_mem;
      logic [31:0] ex_rd;
      do_reset();
      gen_req(0);
      gen_req(1);
      for (int c = 0; c < 800; c++) begin
         drive();
         g      = m_pick(rq_v[0], rq_v[1]);
         own_v  = (m_own >= 0) ? rq_v[m_own] : 1'b0;
         e      = 1'b0;
         ex_mem = '0;
         ex_rd  = 32'd0;
         if (g >= 0) begin
            e = exp_err(rq_a[g], rq_sz[g]);
            if (!e) begin
               ex_mem = {!rq_we[g], rq_we[g], rq_a[g], rq_sz[g], rq_wd[g]};
               b = int'(rq_a[g]) & ~3;
               if (!rq_we[g])
                  ex_rd = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
            end
         end
         step();
         n_chk++;
         if ({s_rdy0, s_rdy1, s_rv0, s_rv1} !== {g == 0, g == 1, g == 0, g == 1}) begin
            n_err++;
            $display("FAIL rnd_grant cyc=%0d got=%b exp_port=%0d", c,
                     {s_rdy0, s_rdy1, s_rv0, s_rv1}, g);
         end
         n_chk++;
         if ({s_re, s_we, s_addr, s_sz, s_wd} !== ex_mem) begin
            n_err++;
            $display("FAIL rnd_mem cyc=%0d got=%h exp=%h", c,
                     {s_re, s_we, s_addr, s_sz, s_wd}, ex_mem);
         end
         n_chk++;
         if ({s_rd0, s_rd1} !== {(g == 0) ? ex_rd : 32'd0, (g == 1) ? ex_rd : 32'd0}) begin
            n_err++;
            $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h port=%0d", c,
                     s_rd0, s_rd1, ex_rd, g);
         end
         if (g >= 0) begin
            n_chk++;
            if (((g == 0) ? s_er0 : s_er1) !== e) begin
               n_err++;
               $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c,
                        (g == 0) ? s_er0 : s_er1, e);
            end
            if (!e && rq_we[g])
               for (int k = 0; k < (1 << rq_sz[g]); k++)
                  ref_mem[int'(rq_a[g]) + k] = rq_wd[g][8*k +: 8];
         end
         m_update(g, (g >= 0) ? rq_lk[g] : 1'b0, own_v);
         for (int p = 0; p < 2; p++) begin
            if (rq_v[p] && g != p) begin
               if ($urandom_range(0, 4) == 0) rq_v[p] = 1'b0;
            end else begin
               gen_req(p);
            end
         end
      end
      clear_reqs();
   endtask

   initial begin
      clear_reqs();
      #2 reset_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_load();
      test_contention();
      test_lock_limit();
      test_errors();
      test_reset_midflight();
      test_abandon();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter in front of the single-ported synchronous data memory. It shares the memory between the core load/store unit (port 0) and the debug/DMA port (port 1) using round-robin arbitration with an optional bounded bus lock. It rejects misaligned and out-of-range accesses without touching memory. It returns exactly one response per accepted request, one cycle after acceptance.

## Interface
Parameters:
- MEM_SIZE, 512, data memory size in bytes; used for range checking.
- LOCK_MAX, 8, maximum consecutive grants a locking requester may hold; range 1..255.

Ports (x = 0, 1 for each requester port):
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reqx_valid  in  1  request present.
- reqx_ready  out  1  request accepted this cycle; combinational.
- reqx_we  in  1  1 = store, 0 = load.
- reqx_lock  in  1  keep the grant on this port after this request.
- reqx_addr  in  32  byte address.
- reqx_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- reqx_wdata  in  32  store data, right-aligned.
- respx_valid  out  1  one-cycle response pulse.
- respx_err  out  1  qualified by respx_valid; 1 = request rejected.
- respx_rdata  out  32  load data, raw memory word; qualified by respx_valid with we = 0 and err = 0. Byte selection and sign extension remain in the LSU.
- mem_read_en, mem_write_en  out  1  memory strobes.
- mem_addr  out  32  memory address.
- mem_store_size  out  2  memory store size.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  registered memory output, valid in the cycle after mem_read_en.

## Operation
- Register state: rr_ptr (port favoured on a tie), lock_owner (none/0/1), lock_cnt (8 bit), and response registers rsp_port, rsp_valid, rsp_err, rsp_we.
- Grant selection is combinational, evaluated in this order:
  - Lock held, owner requesting: grant the owner.
  - Lock held, owner idle: grant the other port if it is requesting.
  - Otherwise, only one port valid: grant it.
  - Otherwise, both ports valid: grant rr_ptr.
- reqx_ready = grant to x. At most one ready per cycle. There are no stalls: the memory accepts every cycle.
- After each grant, rr_ptr moves to the non-granted port.
- Lock rules:
  - A granted request with lock = 1 makes that port lock_owner and increments lock_cnt.
  - The lock releases (owner = none, cnt = 0) when the owner is granted with lock = 0, when lock_cnt reaches LOCK_MAX, or when the owner deasserts valid for a cycle.
  - On forced release at LOCK_MAX, rr_ptr points to the other port.
- Error check (granted request only), error if any of:
  - size = 11;
  - size = 01 with addr[0] = 1;
  - size = 10 with addr[1:0] != 0;
  - addr + bytes > MEM_SIZE. Compute this in 33 bits so there is no wrap at 0xFFFFFFFF.
- Memory drive:
  - Granted and legal: mem_read_en = !we, mem_write_en = we, address/size/data taken from the granted port.
  - Erroneous or no grant: both strobes 0; addr/size/data are 0.
- Response:
  - Registered: respx_valid = rsp_valid && rsp_port == x; respx_err = rsp_err.
  - respx_rdata = mem_read_data when the response is a legal load, else 0. This is a combinational pass-through.
  - Writes get respx_valid with err = 0 and rdata = 0.

## Timing
- Request accepted at edge N (valid and ready high in cycle N-1 → the memory samples the strobes at edge N). Response pulse occurs in the cycle after edge N, for exactly one cycle. Throughput is one request per cycle.
- Back-to-back requests from the same port: respond in order, one per cycle.
- Reset (reset_n low, asynchronous):
  - rr_ptr = 0, lock_owner = none, lock_cnt = 0, rsp_valid = 0.
  - All outputs 0 while asserted: ready, strobes, resp.
- Reset asserted mid-operation drops any pending response. No response is ever produced for a request accepted before reset.
- First cycle after release: normal arbitration, port 0 favoured.
- reqx_* must stay stable while valid and not ready. Dropping valid before ready is permitted (the request is abandoned) and is not an error.

## Test plan
- Single load: port 0 writes word 0xDEADBEEF at address 0x10, then loads 0x10 → resp0_valid one cycle after acceptance, rdata = 0xDEADBEEF, err = 0.
- Contention: both ports request every cycle, lock = 0, for 6 cycles → grants alternate 0,1,0,1,0,1; each response goes to the correct port.
- Lock limit: LOCK_MAX = 4, port 1 requests with lock = 1 continuously while port 0 requests → port 1 gets 4 grants, then port 0 gets 1, then port 1 resumes.
- Errors:
  - Half access at 0x3 → err = 1, no memory strobe.
  - Word access at 0x1FC (MEM_SIZE = 512) → legal.
  - Word access at 0x200 → err.
  - Word access at 0xFFFFFFFC → err.
  - size = 11 → err.
- Reset mid-flight: assert reset_n low in the cycle after a load is accepted → no resp pulse. After release, the first tie is granted to port 0.
- Abandoned request: port 1 raises valid while locked out by a port 0 lock, then drops valid → no port 1 response, and no memory access for it.
